// File: rtl/rot_sweep_pkg.sv
// Shared widths and FSM state type for the rotate-sweep controller.
package rot_sweep_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/rot_sweep_ctrl_shift.sv
// Combinational 8-bit rotate-right: y = a rotated right by amt.
module barrel_shifter (
    input  logic [7:0] a,
    input  logic [2:0] amt,
    output logic [7:0] y
);

    logic [7:0] s1;
    logic [7:0] s2;

    always_comb begin
        s1 = amt[0] ? {a[0],    a[7:1]}  : a;
        s2 = amt[1] ? {s1[1:0], s1[7:2]} : s1;
        y  = amt[2] ? {s2[3:0], s2[7:4]} : s2;
    end

endmodule

// File: rtl/rot_sweep_ctrl.sv
// Job front-end for barrel_shifter: sweeps the rotate amount by STEP per beat
// and streams registered results with amount and last flag.
module rot_sweep_ctrl
    import rot_sweep_pkg::*;
#(
    parameter int unsigned STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_start_amt,
    input  logic [AMT_W-1:0]  in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [AMT_W-1:0]  out_amt,
    output logic              out_last,
    output logic              busy
);

    localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

    state_t            state;
    state_t            state_nx;
    logic [DATA_W-1:0] opnd;
    logic [AMT_W-1:0]  amt;
    logic [AMT_W-1:0]  cnt;
    logic [DATA_W-1:0] y;
    logic              accept;
    logic              fill;
    logic              advance;
    logic              finish;

    barrel_shifter u_shift (
        .a   (opnd),
        .amt (amt),
        .y   (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        fill     = 1'b0;
        advance  = 1'b0;
        finish   = 1'b0;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = S_FILL;
                end
            end
            S_FILL: begin
                fill     = 1'b1;
                state_nx = S_EMIT;
            end
            S_EMIT: begin
                if (out_valid && out_ready) begin
                    if (out_last) begin
                        finish   = 1'b1;
                        state_nx = S_IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FILL and a non-final EMIT handshake both load the next shifter result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd      <= '0;
            amt       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                opnd <= in_data;
                amt  <= in_start_amt;
                cnt  <= in_len;
            end
            if (fill) begin
                out_data  <= y;
                out_amt   <= amt;
                out_last  <= (cnt == '0);
                out_valid <= 1'b1;
                amt       <= amt + STEP_A;
            end
            if (advance) begin
                out_data <= y;
                out_amt  <= amt;
                out_last <= (cnt == AMT_W'(1));
                cnt      <= cnt - AMT_W'(1);
                amt      <= amt + STEP_A;
            end
            if (finish) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rot_sweep_ctrl.sv
// Self-checking bench for rot_sweep_ctrl with STEP=1 and STEP=3 instances.
module tb_rot_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid     [2];
    logic       in_ready     [2];
    logic [7:0] in_data      [2];
    logic [2:0] in_start_amt [2];
    logic [2:0] in_len       [2];
    logic       out_valid    [2];
    logic       out_ready    [2];
    logic [7:0] out_data     [2];
    logic [2:0] out_amt      [2];
    logic       out_last     [2];
    logic       busy         [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rot_sweep_ctrl #(.STEP(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .in_start_amt(in_start_amt[0]), .in_len(in_len[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_amt(out_amt[0]), .out_last(out_last[0]), .busy(busy[0])
    );

    rot_sweep_ctrl #(.STEP(3)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .in_start_amt(in_start_amt[1]), .in_len(in_len[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_amt(out_amt[1]), .out_last(out_last[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_of(input int s);
        return (s == 0) ? 1 : 3;
    endfunction

    // Rotate right computed as a shift of the doubled word
    function automatic logic [7:0] rotr(input logic [7:0] d, input int r);
        logic [15:0] w;
        w = {d, d} >> r;
        return w[7:0];
    endfunction

    // Entered and left at a negedge. mode: 0 ready high, 1 random ready and
    // stray in_valid, 2 three-cycle stall at beat 2 with in_valid pulsed.
    task automatic run_job(input int s, input logic [7:0] d, input logic [2:0] st,
                           input logic [2:0] ln, input int mode);
        int k;
        int budget;
        int stall;
        logic [2:0] a;
        k = 0;
        budget = 0;
        stall = 0;
        chk("idle_in_ready", in_ready[s], 1);
        in_valid[s]     = 1'b1;
        in_data[s]      = d;
        in_start_amt[s] = st;
        in_len[s]       = ln;
        out_ready[s]    = 1'b0;
        @(negedge clk);
        in_valid[s]     = 1'b0;
        in_data[s]      = 8'($urandom);
        in_start_amt[s] = 3'($urandom);
        in_len[s]       = 3'($urandom);
        chk("fill_out_valid", out_valid[s], 0);
        chk("fill_busy", busy[s], 1);
        chk("fill_in_ready", in_ready[s], 0);
        while (k <= int'(ln) && budget < 200) begin
            @(negedge clk);
            budget++;
            a = 3'((int'(st) + k * step_of(s)) % 8);
            chk("beat_valid", out_valid[s], 1);
            chk("beat_data", out_data[s], rotr(d, int'(a)));
            chk("beat_amt", out_amt[s], a);
            chk("beat_last", out_last[s], (k == int'(ln)));
            chk("beat_in_ready", in_ready[s], 0);
            chk("beat_busy", busy[s], 1);
            in_data[s]      = 8'($urandom);
            in_start_amt[s] = 3'($urandom);
            in_len[s]       = 3'($urandom);
            case (mode)
                1: begin
                    out_ready[s] = ($urandom % 3) != 0;
                    in_valid[s]  = 1'($urandom);
                end
                2: begin
                    out_ready[s] = !(k == 2 && stall < 3);
                    in_valid[s]  = (k == 2);
                    if (!out_ready[s]) stall++;
                end
                default: begin
                    out_ready[s] = 1'b1;
                    in_valid[s]  = 1'b0;
                end
            endcase
            @(posedge clk);
            if (out_ready[s]) k++;
        end
        if (budget >= 200) chk("beat_timeout", k, int'(ln) + 1);
        @(negedge clk);
        in_valid[s]  = 1'b0;
        out_ready[s] = 1'b0;
        chk("done_out_valid", out_valid[s], 0);
        chk("done_in_ready", in_ready[s], 1);
        chk("done_busy", busy[s], 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]     = 1'b0;
            in_data[i]      = '0;
            in_start_amt[i] = '0;
            in_len[i]       = '0;
            out_ready[i]    = 1'b0;
        end
        #3;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", in_ready[i], 1);
            chk("rst_busy", busy[i], 0);
            chk("rst_out_valid", out_valid[i], 0);
            chk("rst_out_last", out_last[i], 0);
            chk("rst_out_data", out_data[i], 0);
            chk("rst_out_amt", out_amt[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_job(0, 8'hCC, 3'd0, 3'd7, 0);   // full sweep
        run_job(0, 8'hCC, 3'd6, 3'd3, 0);   // amount wrap
        run_job(0, 8'h01, 3'd0, 3'd7, 0);   // single bit
        run_job(1, 8'h01, 3'd0, 3'd2, 0);   // STEP = 3
        run_job(0, 8'h5A, 3'd2, 3'd6, 2);   // backpressure
        run_job(0, 8'h3C, 3'd5, 3'd0, 0);   // len 0, back to back
        run_job(0, 8'hC3, 3'd1, 3'd0, 0);
        run_job(1, 8'h96, 3'd7, 3'd7, 2);

        // reset in the middle of EMIT
        in_valid[0]     = 1'b1;
        in_data[0]      = 8'hA5;
        in_start_amt[0] = 3'd1;
        in_len[0]       = 3'd7;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", out_valid[0], 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid[0], 0);
        chk("arst_out_data", out_data[0], 0);
        chk("arst_out_amt", out_amt[0], 0);
        chk("arst_out_last", out_last[0], 0);
        chk("arst_in_ready", in_ready[0], 1);
        chk("arst_busy", busy[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_valid", out_valid[0], 0);
            chk("post_rst_in_ready", in_ready[0], 1);
            chk("post_rst_busy", busy[0], 0);
        end
        out_ready[0] = 1'b0;

        for (int j = 0; j < 40; j++) begin
            run_job(j % 2, 8'($urandom), 3'($urandom), 3'($urandom), int'($urandom % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
